// File: rtl/int_to_str.sv
// Sequential 40-bit binary to 12-digit ASCII decimal encoder (double-dabble, one bit per clock).
// Optional macro LEADING_BLANK_EN: leading zero digits are emitted as spaces instead of '0'.
module int_to_str (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [39:0] value,
    output logic        busy,
    output logic        done,
    output logic        ovf,
    output logic [95:0] buffer
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        FMT  = 2'd2
    } state_t;

`ifdef LEADING_BLANK_EN
    localparam logic [95:0] RESET_BUF = {{11{8'h20}}, 8'h30};
`else
    localparam logic [95:0] RESET_BUF = {12{8'h30}};
`endif
    localparam logic [39:0] MAX_VALUE = 40'd999_999_999_999;

    state_t      state_q, state_d;
    logic [39:0] bin_q, bin_d;
    logic [47:0] bcd_q, bcd_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        ovf_next_q, ovf_next_d;
    logic        ovf_q, ovf_d;
    logic [95:0] buffer_q, buffer_d;
    logic        done_q, done_d;

    logic [47:0] bcd_adj;
    logic [95:0] fmt_buf;
    logic [3:0]  digit;
    logic        seen_nz;

    // Shift-add-3 correction applied to every nibble before the shift.
    generate
        for (genvar gi = 0; gi < 12; gi++) begin : g_adj
            assign bcd_adj[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5) ?
                                        bcd_q[gi*4 +: 4] + 4'd3 : bcd_q[gi*4 +: 4];
        end
    endgenerate

    always_comb begin
        fmt_buf = '0;
        digit   = '0;
        seen_nz = 1'b0;
        for (int i = 11; i >= 0; i--) begin
            digit = bcd_q[i*4 +: 4];
            if (digit != 4'd0) seen_nz = 1'b1;
            fmt_buf[i*8 +: 8] = {4'h3, digit};
`ifdef LEADING_BLANK_EN
            // The least significant digit always stays a numeral.
            if (!seen_nz && i != 0) fmt_buf[i*8 +: 8] = 8'h20;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        ovf_next_d = ovf_next_q;
        ovf_d      = ovf_q;
        buffer_d   = buffer_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    bin_d      = value;
                    bcd_d      = '0;
                    cnt_d      = '0;
                    ovf_next_d = (value > MAX_VALUE);
                    state_d    = CONV;
                end
            end
            CONV: begin
                {bcd_d, bin_d} = {bcd_adj[46:0], bin_q, 1'b0};
                cnt_d          = cnt_q + 6'd1;
                if (cnt_q == 6'd39) state_d = FMT;
            end
            FMT: begin
                buffer_d = ovf_next_q ? {12{8'h39}} : fmt_buf;
                ovf_d    = ovf_next_q;
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            bin_q      <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            ovf_next_q <= 1'b0;
            ovf_q      <= 1'b0;
            buffer_q   <= RESET_BUF;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            ovf_next_q <= ovf_next_d;
            ovf_q      <= ovf_d;
            buffer_q   <= buffer_d;
            done_q     <= done_d;
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = done_q;
    assign ovf    = ovf_q;
    assign buffer = buffer_q;

endmodule

// File: tb/tb_int_to_str.sv
// Randomized self-checking bench for int_to_str against an arithmetic decimal-formatting model.
module tb_int_to_str;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [39:0] value;
    logic        busy;
    logic        done;
    logic        ovf;
    logic [95:0] buffer;

    int checks = 0;
    int errors = 0;

    localparam logic [39:0] ONE_T = 40'd1_000_000_000_000;

    always #5 clk = ~clk;

    int_to_str dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .value  (value),
        .busy   (busy),
        .done   (done),
        .ovf    (ovf),
        .buffer (buffer)
    );

    task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: decimal digits by repeated division, saturating to all '9' at >= 10^12.
    function automatic logic [95:0] ref_buf(input logic [39:0] v);
        logic [95:0]     r;
        longint unsigned x;
        x = 64'(v);
        r = '0;
        if (v >= ONE_T) return {12{8'h39}};
        for (int i = 0; i < 12; i++) begin
            r[i*8 +: 8] = 8'h30 + 8'(x % 10);
            x = x / 10;
        end
`ifdef LEADING_BLANK_EN
        for (int i = 11; i >= 1; i--) begin
            if (r[i*8 +: 8] != 8'h30) break;
            r[i*8 +: 8] = 8'h20;
        end
`endif
        return r;
    endfunction

    task automatic run_conv(input string tag, input logic [39:0] v,
                            input bit inject, input logic [39:0] other);
        int lat, busy_cnt, overlap;
        @(negedge clk);
        start = 1'b1;
        value = v;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        value = 40'($urandom);
        lat = 0;
        busy_cnt = busy ? 1 : 0;
        overlap = 0;
        for (int n = 1; n <= 60; n++) begin
            if (inject && (n == 5 || n == 20)) begin
                start = 1'b1;
                value = other;
            end
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            if (busy && done) overlap++;
            if (done) begin
                lat = n;
                break;
            end
            if (busy) busy_cnt++;
        end
        check_eq({tag, "_latency"}, 96'(lat), 96'd41);
        check_eq({tag, "_busy_cycles"}, 96'(busy_cnt), 96'd41);
        check_eq({tag, "_busy_done_overlap"}, 96'(overlap), 96'd0);
        check_eq({tag, "_buffer"}, buffer, ref_buf(v));
        check_eq({tag, "_ovf"}, 96'(ovf), 96'(v >= ONE_T));
        $display("conv %s value=%0d buffer=\"%s\" ovf=%0d latency=%0d", tag, v, buffer, ovf, lat);
        @(posedge clk);
        @(negedge clk);
        check_eq({tag, "_done_width"}, 96'(done), 96'd0);
    endtask

    initial begin
        logic [39:0] v;
        int pulses, prev, saw_done;

        reset = 1'b1;
        start = 1'b0;
        value = '0;
        repeat (3) @(negedge clk);
        check_eq("reset_busy", 96'(busy), 96'd0);
        check_eq("reset_done", 96'(done), 96'd0);
        check_eq("reset_ovf", 96'(ovf), 96'd0);
        check_eq("reset_buffer", buffer, ref_buf(40'd0));
        reset = 1'b0;

        run_conv("zero", 40'd0, 1'b0, 40'd0);
        run_conv("mixed", 40'd123_456_789_012, 1'b0, 40'd0);
        run_conv("max_ok", 40'd999_999_999_999, 1'b0, 40'd0);
        run_conv("ovf_edge", ONE_T, 1'b0, 40'd0);
        run_conv("seven", 40'd7, 1'b0, 40'd0);

        repeat (10) @(negedge clk);
        check_eq("hold_buffer", buffer, ref_buf(40'd7));
        check_eq("hold_ovf", 96'(ovf), 96'd0);

        run_conv("ignored_start", 40'd314_159_265_358, 1'b1, 40'd271_828);

        // Abort a conversion mid-way with reset and start asserted together.
        run_conv("pre_abort", ONE_T + 40'd5, 1'b0, 40'd0);
        @(negedge clk);
        start = 1'b1;
        value = 40'd555;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        check_eq("abort_busy", 96'(busy), 96'd0);
        check_eq("abort_done", 96'(done), 96'd0);
        check_eq("abort_ovf", 96'(ovf), 96'd0);
        check_eq("abort_buffer", buffer, ref_buf(40'd0));
        saw_done = 0;
        for (int c = 0; c < 45; c++) begin
            @(negedge clk);
            if (done || busy) saw_done++;
        end
        check_eq("abort_no_done", 96'(saw_done), 96'd0);
        $display("abort busy=%0d done=%0d buffer=\"%s\"", busy, done, buffer);

        run_conv("all_ones", 40'hFF_FFFF_FFFF, 1'b0, 40'd0);

        for (int k = 0; k < 16; k++) begin
            v = {8'($urandom), 32'($urandom)};
            if (k % 2 == 1) v = v % ONE_T;
            if (k % 4 == 2) v = 40'($urandom_range(0, 99999));
            run_conv($sformatf("rand%0d", k), v, 1'b0, 40'd0);
        end

        // start held high: one result every 42 cycles.
        @(negedge clk);
        start = 1'b1;
        value = 40'd42;
        pulses = 0;
        prev = 0;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                pulses++;
                check_eq("held_gap", 96'(c - prev), 96'(pulses == 1 ? 42 : 42));
                check_eq("held_buffer", buffer, ref_buf(40'd42));
                $display("held pulse=%0d cycle=%0d buffer=\"%s\"", pulses, c, buffer);
                prev = c;
            end
        end
        check_eq("held_pulses", 96'(pulses), 96'd4);
        start = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (!busy && !done) break;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
